// File: rtl/bitstream_frame_ctrl_if.sv
// Host/fabric-side signal bundle of the bitstream frame sequencer.
// The slave modport is the sequencer itself; master is whoever drives requests.
interface bitstream_frame_ctrl_if #(
  parameter int CNT_W = 11
) ();
  logic             start;
  logic             abort;
  logic             stream_in;
  logic             result_ready;
  logic             gen_n_rst;
  logic             gen_en;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] bit_idx;
  logic [CNT_W-1:0] count;

  modport master (
    output start, abort, stream_in, result_ready,
    input  gen_n_rst, gen_en, bit_idx, busy, result_valid, count
  );

  modport slave (
    input  start, abort, stream_in, result_ready,
    output gen_n_rst, gen_en, bit_idx, busy, result_valid, count
  );
endinterface

// File: rtl/bitstream_frame_ctrl.sv
// Frame sequencer: realigns the constant-bitstream generators, runs one frame,
// counts ones on the network output and hands the count over with valid/ready.
module bitstream_frame_ctrl #(
  parameter int LENGTH       = 1092,
  parameter int ALIGN_CYCLES = 2,
  parameter int LAT          = 0,
  parameter int CNT_W        = $clog2(LENGTH + 1)
) (
  input logic                   clk,
  input logic                   n_rst,
  bitstream_frame_ctrl_if.slave bus
);
  localparam int AW = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
  localparam int PW = (LAT > 0) ? LAT : 1;

  typedef enum logic [2:0] {IDLE, ALIGN, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    align_cnt_q, align_cnt_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    en_pipe_q, en_pipe_d;
  logic             gen_n_rst_q, gen_n_rst_d;
  logic             gen_en_q, gen_en_d;
  logic             busy_q, busy_d;
  logic             result_valid_q, result_valid_d;
  logic             cnt_en;
  logic             abort_now;

  // gen_en delayed by LAT cycles lines each sampled stream bit up with its generator bit
  assign cnt_en = (LAT == 0) ? gen_en_q : en_pipe_q[PW-1];

  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    drain_cnt_d = drain_cnt_q;
    bit_idx_d   = '0;
    count_d     = count_q;
    en_pipe_d   = (en_pipe_q << 1) | PW'(gen_en_q);
    abort_now   = 1'b0;

    if (cnt_en && bus.stream_in) begin
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = ALIGN;
          align_cnt_d = '0;
          count_d     = '0;
        end
      end
      ALIGN: begin
        if (align_cnt_q == AW'(ALIGN_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          align_cnt_d = align_cnt_q + AW'(1);
        end
      end
      RUN: begin
        if (bit_idx_q == CNT_W'(LENGTH - 1)) begin
          state_d     = (LAT > 0) ? DRAIN : DONE;
          drain_cnt_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == 4'(LAT - 1)) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort drops the frame and pulses the generator reset so they cannot free-run misaligned
    if (bus.abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      abort_now = 1'b1;
      count_d   = '0;
      en_pipe_d = '0;
      bit_idx_d = '0;
    end

    gen_n_rst_d    = (state_d != ALIGN) && !abort_now;
    gen_en_d       = (state_d == RUN);
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      align_cnt_q    <= '0;
      drain_cnt_q    <= '0;
      bit_idx_q      <= '0;
      count_q        <= '0;
      en_pipe_q      <= '0;
      gen_n_rst_q    <= 1'b0;
      gen_en_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      align_cnt_q    <= align_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      bit_idx_q      <= bit_idx_d;
      count_q        <= count_d;
      en_pipe_q      <= en_pipe_d;
      gen_n_rst_q    <= gen_n_rst_d;
      gen_en_q       <= gen_en_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.gen_n_rst    = gen_n_rst_q;
  assign bus.gen_en       = gen_en_q;
  assign bus.bit_idx      = bit_idx_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.count        = count_q;
endmodule

// File: tb/tb_bitstream_frame_ctrl.sv
// Directed bench for bitstream_frame_ctrl with three parameterisations
// (8-bit frame LAT=0, full-length frame LAT=3, 8-bit frame LAT=2).
module tb_bitstream_frame_ctrl;
  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  bitstream_frame_ctrl_if #(.CNT_W(4))  a_if ();
  bitstream_frame_ctrl_if #(.CNT_W(11)) b_if ();
  bitstream_frame_ctrl_if #(.CNT_W(4))  c_if ();

  bitstream_frame_ctrl #(.LENGTH(8), .ALIGN_CYCLES(2), .LAT(0), .CNT_W(4)) u_a (
    .clk(clk), .n_rst(n_rst), .bus(a_if)
  );
  bitstream_frame_ctrl #(.LENGTH(1092), .ALIGN_CYCLES(2), .LAT(3), .CNT_W(11)) u_b (
    .clk(clk), .n_rst(n_rst), .bus(b_if)
  );
  bitstream_frame_ctrl #(.LENGTH(8), .ALIGN_CYCLES(2), .LAT(2), .CNT_W(4)) u_c (
    .clk(clk), .n_rst(n_rst), .bus(c_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic score(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0d expected nothing queued", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // 20 ones in 1092 bits, including both frame edges
  function automatic logic pat(input int k);
    if (k < 0 || k > 1091) return 1'b0;
    return (k == 0) || (k == 1091) || ((k % 50 == 7) && (k >= 57) && (k <= 907));
  endfunction

  initial begin
    int first;
    int n;
    int exp_c[3];
    exp_c[0] = 0;
    exp_c[1] = 8;
    exp_c[2] = 2;

    n_rst = 1'b0;
    a_if.start = 0; a_if.abort = 0; a_if.stream_in = 0; a_if.result_ready = 1;
    b_if.start = 0; b_if.abort = 0; b_if.stream_in = 0; b_if.result_ready = 1;
    c_if.start = 0; c_if.abort = 0; c_if.stream_in = 0; c_if.result_ready = 1;
    tick();
    tick();
    check("rst_gen_n_rst", a_if.gen_n_rst, 0);
    check("rst_gen_en", a_if.gen_en, 0);
    check("rst_bit_idx", a_if.bit_idx, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_valid", a_if.result_valid, 0);
    check("rst_count", a_if.count, 0);
    n_rst = 1'b1;
    tick();
    check("idle_gen_n_rst", a_if.gen_n_rst, 1);
    check("idle_busy", a_if.busy, 0);

    // Basic frame, stream constantly 1
    a_if.stream_in = 1;
    a_if.start = 1;
    exp_q.push_back(8);
    tick();
    a_if.start = 0;
    for (int i = 0; i < 2; i++) begin
      check("t1_align_gen_n_rst", a_if.gen_n_rst, 0);
      check("t1_align_gen_en", a_if.gen_en, 0);
      check("t1_align_busy", a_if.busy, 1);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      check("t1_run_gen_en", a_if.gen_en, 1);
      check("t1_run_bit_idx", a_if.bit_idx, k);
      check("t1_run_gen_n_rst", a_if.gen_n_rst, 1);
      check("t1_run_valid", a_if.result_valid, 0);
      tick();
    end
    check("t1_valid", a_if.result_valid, 1);
    score("t1_count", a_if.count);
    tick();
    check("t1_busy_after", a_if.busy, 0);
    check("t1_valid_after", a_if.result_valid, 0);

    // Handshake stall of 50 cycles with ignored start pulses
    a_if.result_ready = 0;
    a_if.start = 1;
    exp_q.push_back(8);
    tick();
    a_if.start = 0;
    repeat (9) tick();
    check("t2_valid_early", a_if.result_valid, 0);
    tick();
    check("t2_valid_rise", a_if.result_valid, 1);
    score("t2_count", a_if.count);
    for (int i = 0; i < 50; i++) begin
      check("t2_hold_valid", a_if.result_valid, 1);
      check("t2_hold_count", a_if.count, 8);
      a_if.start = (i % 10 == 5);
      tick();
    end
    check("t2_still_valid", a_if.result_valid, 1);
    a_if.result_ready = 1;
    a_if.start = 1;
    tick();
    a_if.start = 0;
    check("t2_idle_busy", a_if.busy, 0);
    check("t2_idle_valid", a_if.result_valid, 0);
    check("t2_count_retained", a_if.count, 8);
    tick();
    check("t2_start_dropped", a_if.busy, 0);

    // Abort at bit 4
    a_if.start = 1;
    tick();
    a_if.start = 0;
    tick();
    tick();
    repeat (4) tick();
    check("t3_bit_idx4", a_if.bit_idx, 4);
    a_if.abort = 1;
    tick();
    a_if.abort = 0;
    check("t3_abort_busy", a_if.busy, 0);
    check("t3_abort_count", a_if.count, 0);
    check("t3_abort_gen_n_rst", a_if.gen_n_rst, 0);
    check("t3_abort_gen_en", a_if.gen_en, 0);
    check("t3_abort_valid", a_if.result_valid, 0);
    tick();
    check("t3_gen_n_rst_release", a_if.gen_n_rst, 1);
    for (int i = 0; i < 15; i++) begin
      check("t3_no_valid", a_if.result_valid, 0);
      tick();
    end
    a_if.start = 1;
    exp_q.push_back(8);
    tick();
    a_if.start = 0;
    n = 1;
    while (!a_if.result_valid && n < 40) begin
      tick();
      n++;
    end
    check("t3_valid_timeout", a_if.result_valid, 1);
    check("t3_latency", n, 11);
    score("t3_count", a_if.count);
    tick();

    // Synchronous reset mid-RUN
    a_if.start = 1;
    tick();
    a_if.start = 0;
    repeat (5) tick();
    check("t4_bit_idx3", a_if.bit_idx, 3);
    n_rst = 0;
    #3;
    check("t4_pre_edge_busy", a_if.busy, 1);
    check("t4_pre_edge_gen_en", a_if.gen_en, 1);
    check("t4_pre_edge_bit_idx", a_if.bit_idx, 3);
    tick();
    n_rst = 1;
    check("t4_rst_gen_n_rst", a_if.gen_n_rst, 0);
    check("t4_rst_gen_en", a_if.gen_en, 0);
    check("t4_rst_bit_idx", a_if.bit_idx, 0);
    check("t4_rst_busy", a_if.busy, 0);
    check("t4_rst_valid", a_if.result_valid, 0);
    check("t4_rst_count", a_if.count, 0);
    tick();
    check("t4_idle_gen_n_rst", a_if.gen_n_rst, 1);
    check("t4_idle_busy", a_if.busy, 0);
    for (int i = 0; i < 12; i++) begin
      check("t4_no_valid", a_if.result_valid, 0);
      tick();
    end
    a_if.stream_in = 0;

    // Full-length frame, LAT=3, 20-ones pattern
    b_if.start = 1;
    exp_q.push_back(20);
    tick();
    b_if.start = 0;
    first = 0;
    for (int k = 1; k <= 1200; k++) begin
      if (b_if.result_valid) begin
        first = k;
        break;
      end
      b_if.stream_in = pat(k - 6);
      tick();
    end
    check("t5_latency", first, 1098);
    score("t5_count", b_if.count);
    b_if.stream_in = 0;
    tick();
    check("t5_idle_busy", b_if.busy, 0);

    // LAT=2 counting window: outside only, inside only, both edges only
    for (int f = 0; f < 3; f++) begin
      c_if.stream_in = (f == 0);
      c_if.start = 1;
      exp_q.push_back(exp_c[f]);
      tick();
      c_if.start = 0;
      for (int k = 1; k <= 13; k++) begin
        case (f)
          0:       c_if.stream_in = (k < 5) || (k > 12);
          1:       c_if.stream_in = (k >= 5) && (k <= 12);
          default: c_if.stream_in = (k == 5) || (k == 12);
        endcase
        if (k == 12) check("t6_valid_early", c_if.result_valid, 0);
        if (k == 13) begin
          check("t6_valid", c_if.result_valid, 1);
          score("t6_count", c_if.count);
        end
        tick();
      end
      c_if.stream_in = 0;
      check("t6_idle_busy", c_if.busy, 0);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
